muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Consumes the two register-file read ports (rs operand from read port 1, rt operand from read port 2) when the decoder issues MULT/MULTU/DIV/DIVU.
- Performs one shift-add or restoring-subtract step per clock and holds HI/LO for MFHI/MFLO.
- hi_out/lo_out feed the write-back mux that drives the register-file write data.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// one step per clock, with architectural HI/LO registers for MFHI/MFLO.
module muldiv_unit #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] rs_in,
   input  logic [W-1:0] rt_in,
   input  logic         mthi,
   input  logic         mtlo,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi_out,
   output logic [W-1:0] lo_out
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   // Issue handshake: start is taken only while busy is low; done pulses
   // for exactly one cycle when HI/LO have been committed by an operation.
   state_t          state;
   logic [CW-1:0]   cnt;
   logic            is_div;
   logic            neg_q;
   logic            neg_r;
   logic            div_zero;
   logic [W-1:0]    opnd_b;
   logic [W-1:0]    rs_orig;
   logic [2*W-1:0]  acc;

   logic            rs_neg;
   logic            rt_neg;
   logic [W-1:0]    rs_mag;
   logic [W-1:0]    rt_mag;
   logic [W:0]      mul_sum;
   logic [2*W-1:0]  div_sh;
   logic [W:0]      div_trial;
   logic [2*W-1:0]  prod_neg;

   always_comb begin
      rs_neg    = ~op[0] & rs_in[W-1];
      rt_neg    = ~op[0] & rt_in[W-1];
      // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
      rs_mag    = rs_neg ? (~rs_in + 1'b1) : rs_in;
      rt_mag    = rt_neg ? (~rt_in + 1'b1) : rt_in;
      mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd_b};
      div_sh    = {acc[2*W-2:0], 1'b0};
      // Bit shifted out of the remainder is kept so the trial never loses range.
      div_trial = {acc[2*W-1], div_sh[2*W-1:W]} - {1'b0, opnd_b};
      prod_neg  = ~acc + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         opnd_b   <= '0;
         rs_orig  <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_q    <= rs_neg ^ rt_neg;
                  neg_r    <= rs_neg;
                  div_zero <= op[1] & (rt_in == '0);
                  rs_orig  <= rs_in;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
                  if (op[1]) begin
                     acc    <= {{W{1'b0}}, rs_mag};
                     opnd_b <= rt_mag;
                  end else begin
                     acc    <= {{W{1'b0}}, rt_mag};
                     opnd_b <= rs_mag;
                  end
               end else begin
                  if (mthi) hi_out <= rs_in;
                  if (mtlo) lo_out <= rs_in;
               end
            end
            RUN: begin
               if (is_div) begin
                  if (!div_trial[W]) acc <= {div_trial[W-1:0], div_sh[W-1:1], 1'b1};
                  else               acc <= div_sh;
               end else begin
                  if (acc[0]) acc <= {mul_sum, acc[W-1:1]};
                  else        acc <= {1'b0, acc[2*W-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W-1)) state <= FIX;
            end
            FIX: begin
               if (!is_div) begin
                  {hi_out, lo_out} <= neg_q ? prod_neg : acc;
               end else if (div_zero) begin
                  hi_out <= rs_orig;
                  lo_out <= '1;
               end else begin
                  lo_out <= neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
                  hi_out <= neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed MULT/MULTU/DIV/DIVU results,
// edge-accurate latency, MTHI/MTLO, ignored issue while busy, async reset abort.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clock;
   logic         reset_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs_in;
   logic [W-1:0] rt_in;
   logic         mthi;
   logic         mtlo;
   logic         busy;
   logic         done;
   logic [W-1:0] hi_out;
   logic [W-1:0] lo_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_bad = 0;

   muldiv_unit #(.W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .rs_in   (rs_in),
      .rt_in   (rt_in),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .busy    (busy),
      .done    (done),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one issue; returns at the negedge of cycle 1 (just after the start edge).
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      start = 1'b1;
      op    = o;
      rs_in = a;
      rt_in = b;
      @(negedge clock);
      start    = 1'b0;
      rs_in    = $urandom;
      rt_in    = $urandom;
      cyc      = 1;
      busy_bad = 0;
   endtask

   task automatic step_busy(input int n);
      for (int i = 0; i < n; i++) begin
         if (busy !== 1'b1) busy_bad++;
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic wait_done(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      while (done !== 1'b1 && cyc < 80) begin
         if (busy !== 1'b1) busy_bad++;
         @(negedge clock);
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'd34);
      check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
      check({tag, "_busy_fall"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
      @(negedge clock);
      check({tag, "_done_fall"}, 64'(done), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      rs_in   = '0;
      rt_in   = '0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi_out), 64'd0);
      check("rst_lo", 64'(lo_out), 64'd0);
      reset_n = 1'b1;

      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

      start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_done("mult_min", 32'h4000_0000, 32'h0000_0000);

      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      start_op(2'b11, 32'd7, 32'd2);
      wait_done("divu", 32'd1, 32'd3);

      start_op(2'b11, 32'd5, 32'd0);
      wait_done("divu_zero", 32'd5, 32'hFFFF_FFFF);

      start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 32'h0000_0000, 32'h8000_0000);

      start_op(2'b10, 32'hFFFF_FFF9, 32'd0);
      wait_done("div_zero_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // MTHI in IDLE; LO must keep its value from the last divide.
      @(negedge clock);
      mthi  = 1'b1;
      rs_in = 32'h0000_1234;
      @(negedge clock);
      mthi  = 1'b0;
      rs_in = 32'h5555_5555;
      check("mthi_hi", 64'(hi_out), 64'h1234);
      check("mthi_lo_kept", 64'(lo_out), 64'hFFFF_FFFF);

      // Issue attempts while busy are dropped.
      start_op(2'b11, 32'd9, 32'd4);
      step_busy(4);
      start = 1'b1;
      mtlo  = 1'b1;
      op    = 2'b01;
      rs_in = 32'h0000_AAAA;
      rt_in = 32'h0000_0003;
      step_busy(1);
      start = 1'b0;
      mtlo  = 1'b0;
      wait_done("busy_ignore", 32'd1, 32'd2);
      check("busy_ignore_idle", 64'(busy), 64'd0);

      // Async reset in the middle of RUN.
      start_op(2'b01, 32'h1234_5678, 32'd9);
      step_busy(10);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi_out), 64'd0);
      check("abort_lo", 64'(lo_out), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("abort_stays_idle", 64'(busy), 64'd0);

      start_op(2'b01, 32'd3, 32'd5);
      wait_done("post_rst", 32'd0, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
